flt_topk: RTL and testbench
===========================

FLT_TOPK -- requirements
Module: flt_topk

Interface
REQ-001 Parameter N_W, default 2, width of entrant id; id 0 is reserved as "no entry".
REQ-002 Parameter T_W, default 8, width of time value.
REQ-003 Parameter K, default 3, number of ranked slots; legal range 1..2^N_W-1.
REQ-004 Parameter MODE_MAX, default 0; 0 ranks smallest t best, 1 ranks largest t best.
REQ-005 clk  in  1  the block's one clock; all state changes on its rising edge.
REQ-006 reset  in  1  reset is synchronous and active-low; reset=0 at a clk rising edge resets the block.
REQ-007 clr  in  1  synchronous round restart; empties the ranking without a reset.
REQ-008 n  in  N_W  entrant id of the current sample; 0 means no sample this cycle.
REQ-009 t  in  T_W  time of the current sample; ignored when n=0.
REQ-010 n_best  out  N_W  id holding rank 0; 0 when the ranking is empty.
REQ-011 t_best  out  T_W  time at rank 0.
REQ-012 rank_n  out  K*N_W  ids of ranks 0..K-1, rank 0 in the least significant field.
REQ-013 rank_t  out  K*T_W  times of ranks 0..K-1, same packing as rank_n.
REQ-014 count  out  N_W  number of occupied ranks, 0..K.

Function
REQ-015 All outputs are registered; a sample presented before an edge is reflected in every output immediately after that edge (latency 1).
REQ-016 "Better" is strictly less than in MIN mode and strictly greater than in MAX mode, compared unsigned over the full T_W bits.
REQ-017 Each id occupies at most one rank and holds that entrant's personal best.
REQ-018 If sample id n is not ranked, the sample is inserted at the first rank whose time is not better-or-equal to t; lower ranks shift down one place.
REQ-019 Ties rank the earlier sample ahead; an equal new time is inserted after all equal entries.
REQ-020 When the ranking is full and the new time ranks below slot K-1, the sample is dropped; otherwise slot K-1 is evicted.
REQ-021 If sample id n is already ranked and t is better, the old entry is removed and the sample is reinserted per REQ-018/019 in the same cycle; count is unchanged.
REQ-022 If sample id n is already ranked and t is equal or worse, the state is unchanged.
REQ-023 Unoccupied ranks read id 0 and the empty time: all-ones in MIN mode, all-zeros in MAX mode.
REQ-024 n=0 leaves all state unchanged regardless of t.
REQ-025 clr=1 with n=0 empties the ranking at the edge.
REQ-026 clr=1 with n!=0 empties the ranking and loads the sample as the sole entry; count becomes 1.
REQ-027 Occupied ranks are always contiguous from rank 0 and ordered best-first.

Reset
REQ-028 reset=0 at a rising edge empties the ranking: count=0, n_best=0, t_best=empty time, every rank per REQ-023.
REQ-029 Reset overrides clr and any sample in the same cycle.
REQ-030 Reset asserted mid-round discards all ranks, and the first sample after deassertion is ranked as in an empty round.

Structure
REQ-031 Shared package flt_pkg holds the empty-time constant function, the reserved id 0 constant and the MIN/MAX mode encodings.
REQ-032 One sub-module, flt_cmp, combinationally implements the "better" and "equal" comparison for the selected mode; it is instantiated once per rank.
REQ-033 Rank storage is a single K-deep register array of {id, time}; insertion and removal are one combinational shift network with no multicycle paths.

Verification
REQ-034 Default parameters: reset, then (1,128),(2,127),(3,129) -> ranks (2,127),(1,128),(3,129); count=3.
REQ-035 Continuing: (2,126) -> (2,126),(1,128),(3,129); then (2,129) -> unchanged; then (1,124) -> (1,124),(2,126),(3,129).
REQ-036 Tie: reset, then (1,50),(2,50) -> rank 0 = (1,50), rank 1 = (2,50); n=0 with t=0 -> unchanged.
REQ-037 K=2, N_W=2: (1,10),(2,20),(3,15) -> (1,10),(3,15); then (2,30) -> dropped, ranks unchanged.
REQ-038 clr: clr=1 with (3,200) -> count=1, n_best=3, t_best=200, ranks 1..K-1 id 0 / t 255; clr=1 with n=0 -> count=0.
REQ-039 MODE_MAX=1: (1,5),(2,9) -> n_best=2, t_best=9; reset=0 together with (3,99) -> empty ranks read t=0, count=0; random 200-cycle run compared each cycle against a behavioural model.

Source files
------------

// File: rtl/flt_pkg.sv
// flt_pkg: shared definitions for the top-K time ranking block.
//   ID_NONE       reserved entrant id meaning "no entry / no sample"
//   MODE_SEL_MIN  ranking mode where the smallest time is best
//   MODE_SEL_MAX  ranking mode where the largest time is best
//   empty_time()  time value shown by an unoccupied rank for a given mode/width
package flt_pkg;
   localparam int ID_NONE      = 0;
   localparam bit MODE_SEL_MIN = 1'b0;
   localparam bit MODE_SEL_MAX = 1'b1;

   // Unoccupied ranks show the worst possible time for the mode, so that an
   // empty slot never looks better than a real one when read externally.
   function automatic logic [63:0] empty_time(input bit mode_max, input int w);
      return (mode_max == MODE_SEL_MAX) ? 64'd0 : ~(~64'd0 << w);
   endfunction
endpackage

// File: rtl/flt_cmp.sv
// flt_cmp: mode-aware time comparator, one instance per rank.
//   a_i, b_i  times to compare (unsigned, full width)
//   better_o  a_i ranks strictly ahead of b_i in the selected mode
//   equal_o   a_i equals b_i
module flt_cmp
   import flt_pkg::*;
#(
   parameter int T_W      = 8,
   parameter bit MODE_MAX = 1'b0
) (
   input  logic [T_W-1:0] a_i,
   input  logic [T_W-1:0] b_i,
   output logic           better_o,
   output logic           equal_o
);
   assign better_o = (MODE_MAX == MODE_SEL_MIN) ? (a_i < b_i) : (a_i > b_i);
   assign equal_o  = (a_i == b_i);
endmodule

// File: rtl/flt_topk.sv
// flt_topk: keeps the K best personal-best times of up to 2^N_W-1 entrants.
//   clk     rising-edge clock
//   reset   synchronous active-low reset, overrides clr and samples
//   clr     round restart: empties ranking (and loads the sample if n!=0)
//   n, t    sample id (0 = none) and time
//   n_best, t_best   rank 0 entry
//   rank_n, rank_t   all ranks, rank 0 in the least significant field
//   count   number of occupied ranks
module flt_topk
   import flt_pkg::*;
#(
   parameter int N_W      = 2,
   parameter int T_W      = 8,
   parameter int K        = 3,
   parameter bit MODE_MAX = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic [N_W-1:0]   n,
   input  logic [T_W-1:0]   t,
   output logic [N_W-1:0]   n_best,
   output logic [T_W-1:0]   t_best,
   output logic [K*N_W-1:0] rank_n,
   output logic [K*T_W-1:0] rank_t,
   output logic [N_W-1:0]   count
);
   typedef struct packed {
      logic [N_W-1:0] id;
      logic [T_W-1:0] t;
   } ent_t;

   localparam logic [T_W-1:0] EMPTY_T = T_W'(empty_time(MODE_MAX, T_W));
   localparam ent_t           EMPTY_E = '{id: '0, t: EMPTY_T};

   ent_t           ent_q [K];
   ent_t           ent_d [K];
   logic [N_W-1:0] count_q, count_d;

   // Entries extended with one empty slot so the compaction shift has a source
   // for the last rank.
   ent_t           ent_x [K+1];
   logic [K:0]     occ_x, ge_x;
   ent_t           rem   [K];
   logic [K-1:0]   rem_occ, rem_ge;
   ent_t           ins   [K];
   ent_t           smp;
   logic [K-1:0]   hit, cmp_better, cmp_equal;
   logic           any_hit, improve, seen;
   int             pos, cnt;

   // ge: stored time is better-or-equal to the incoming t.
   for (genvar g = 0; g < K; g++) begin : g_cmp
      flt_cmp #(.T_W(T_W), .MODE_MAX(MODE_MAX)) u_cmp (
         .a_i      (ent_q[g].t),
         .b_i      (t),
         .better_o (cmp_better[g]),
         .equal_o  (cmp_equal[g])
      );
   end

   always_comb begin
      smp = '{id: n, t: t};
      for (int i = 0; i < K; i++) begin
         ent_x[i] = ent_q[i];
         occ_x[i] = (ent_q[i].id != N_W'(ID_NONE));
         ge_x[i]  = cmp_better[i] | cmp_equal[i];
         hit[i]   = occ_x[i] && (ent_q[i].id == n);
      end
      ent_x[K] = EMPTY_E;
      occ_x[K] = 1'b0;
      ge_x[K]  = 1'b0;

      any_hit = |hit;
      improve = |(hit & ~ge_x[K-1:0]);

      // Remove the entrant's old entry (only when it improves) by shifting
      // every later rank up one place.
      seen = 1'b0;
      for (int i = 0; i < K; i++) begin
         seen       = seen | (improve & hit[i]);
         rem[i]     = seen ? ent_x[i+1] : ent_x[i];
         rem_occ[i] = seen ? occ_x[i+1] : occ_x[i];
         rem_ge[i]  = seen ? ge_x[i+1]  : ge_x[i];
      end

      // First rank that is empty or strictly worse than t; equal times stay
      // ahead. pos == K means the sample falls off the end.
      pos = K;
      for (int i = K-1; i >= 0; i--)
         if (!rem_occ[i] || !rem_ge[i]) pos = i;

      for (int i = 0; i < K; i++) begin
         if (i < pos)       ins[i] = rem[i];
         else if (i == pos) ins[i] = smp;
         else               ins[i] = rem[(i > 0) ? i-1 : 0];
      end

      ent_d = ent_q;
      if (clr) begin
         for (int i = 0; i < K; i++) ent_d[i] = EMPTY_E;
         if (n != N_W'(ID_NONE)) ent_d[0] = smp;
      end else if (n != N_W'(ID_NONE) && (!any_hit || improve)) begin
         ent_d = ins;
      end

      cnt = 0;
      for (int i = 0; i < K; i++)
         if (ent_d[i].id != N_W'(ID_NONE)) cnt = cnt + 1;
      count_d = N_W'(cnt);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < K; i++) ent_q[i] <= EMPTY_E;
         count_q <= '0;
      end else begin
         for (int i = 0; i < K; i++) ent_q[i] <= ent_d[i];
         count_q <= count_d;
      end
   end

   always_comb begin
      rank_n = '0;
      rank_t = '0;
      for (int i = 0; i < K; i++) begin
         rank_n[i*N_W +: N_W] = ent_q[i].id;
         rank_t[i*T_W +: T_W] = ent_q[i].t;
      end
   end

   assign n_best = ent_q[0].id;
   assign t_best = ent_q[0].t;
   assign count  = count_q;
endmodule

// File: tb/tb_flt_topk.sv
// tb_flt_topk: drives one shared stimulus into three configurations
// (default, K=2, MODE_MAX=1); a per-configuration list model predicts the
// ranking, predictions are queued at drive time and compared after the edge.
module tb_flt_topk;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, clr;
   logic [1:0] n;
   logic [7:0] t;

   logic [1:0]  nb0, nb1, nb2, cn0, cn1, cn2;
   logic [7:0]  tb0, tb1, tb2;
   logic [5:0]  rn0, rn2;
   logic [3:0]  rn1;
   logic [23:0] rt0, rt2;
   logic [15:0] rt1;

   flt_topk u_d0 (.clk(clk), .reset(reset), .clr(clr), .n(n), .t(t),
                  .n_best(nb0), .t_best(tb0), .rank_n(rn0), .rank_t(rt0), .count(cn0));
   flt_topk #(.K(2)) u_d1 (.clk(clk), .reset(reset), .clr(clr), .n(n), .t(t),
                  .n_best(nb1), .t_best(tb1), .rank_n(rn1), .rank_t(rt1), .count(cn1));
   flt_topk #(.MODE_MAX(1'b1)) u_d2 (.clk(clk), .reset(reset), .clr(clr), .n(n), .t(t),
                  .n_best(nb2), .t_best(tb2), .rank_n(rn2), .rank_t(rt2), .count(cn2));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- model ----------------
   int mid  [3][4];
   int mt   [3][4];
   int mcnt [3];

   function automatic int kk(input int d);
      return (d == 1) ? 2 : 3;
   endfunction

   function automatic bit bet(input int d, input int a, input int b);
      return (d == 2) ? (a > b) : (a < b);
   endfunction

   function automatic void mstep(input int d, input logic r, input logic c,
                                 input int nn, input int tt);
      int h, p, k;
      k = kk(d);
      if (!r) begin
         mcnt[d] = 0;
      end else if (c) begin
         mcnt[d] = 0;
         if (nn != 0) begin
            mid[d][0] = nn; mt[d][0] = tt; mcnt[d] = 1;
         end
      end else if (nn != 0) begin
         h = -1;
         for (int i = 0; i < mcnt[d]; i++) if (mid[d][i] == nn) h = i;
         if (h >= 0) begin
            if (!bet(d, tt, mt[d][h])) return;
            for (int i = h; i < mcnt[d]-1; i++) begin
               mid[d][i] = mid[d][i+1]; mt[d][i] = mt[d][i+1];
            end
            mcnt[d]--;
         end
         p = 0;
         for (int i = 0; i < mcnt[d]; i++) if (!bet(d, tt, mt[d][i])) p = i + 1;
         if (p >= k) return;
         if (mcnt[d] < k) mcnt[d]++;
         for (int i = mcnt[d]-1; i > p; i--) begin
            mid[d][i] = mid[d][i-1]; mt[d][i] = mt[d][i-1];
         end
         mid[d][p] = nn; mt[d][p] = tt;
      end
   endfunction

   function automatic logic [31:0] pk_n(input int d);
      logic [31:0] v = '0;
      for (int i = 0; i < kk(d); i++)
         if (i < mcnt[d]) v = v | (32'(mid[d][i]) << (2*i));
      return v;
   endfunction

   function automatic logic [31:0] pk_t(input int d);
      logic [31:0] v = '0;
      int e;
      e = (d == 2) ? 0 : 255;
      for (int i = 0; i < kk(d); i++)
         v = v | (32'((i < mcnt[d]) ? mt[d][i] : e) << (8*i));
      return v;
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      int          d;
      logic [31:0] rn, rt, cn, nb, tb;
   } exp_t;
   exp_t sbq[$];

   task automatic cyc(input logic r, input logic c, input int nn, input int tt);
      exp_t        e;
      logic [31:0] arn, art, acn, anb, atb;
      reset = r; clr = c; n = nn[1:0]; t = tt[7:0];
      for (int d = 0; d < 3; d++) begin
         mstep(d, r, c, nn, tt);
         e.d  = d;
         e.rn = pk_n(d);
         e.rt = pk_t(d);
         e.cn = 32'(mcnt[d]);
         e.nb = (mcnt[d] > 0) ? 32'(mid[d][0]) : 32'd0;
         e.tb = (mcnt[d] > 0) ? 32'(mt[d][0]) : ((d == 2) ? 32'd0 : 32'd255);
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         case (e.d)
            0:       begin arn = 32'(rn0); art = 32'(rt0); acn = 32'(cn0); anb = 32'(nb0); atb = 32'(tb0); end
            1:       begin arn = 32'(rn1); art = 32'(rt1); acn = 32'(cn1); anb = 32'(nb1); atb = 32'(tb1); end
            default: begin arn = 32'(rn2); art = 32'(rt2); acn = 32'(cn2); anb = 32'(nb2); atb = 32'(tb2); end
         endcase
         chk($sformatf("d%0d_rank_n", e.d), arn, e.rn);
         chk($sformatf("d%0d_rank_t", e.d), art, e.rt);
         chk($sformatf("d%0d_count",  e.d), acn, e.cn);
         chk($sformatf("d%0d_n_best", e.d), anb, e.nb);
         chk($sformatf("d%0d_t_best", e.d), atb, e.tb);
      end
   endtask

   initial begin
      logic r, c;
      int   nn, tt;

      // reset state
      cyc(1'b0, 1'b0, 0, 0);
      chk("rst_count", 32'(cn0), 32'd0);
      chk("rst_t_min", 32'(tb0), 32'd255);
      chk("rst_t_max", 32'(rt2), 32'd0);

      // basic ordering, improvement, worse retry
      cyc(1'b1, 1'b0, 1, 128);
      cyc(1'b1, 1'b0, 2, 127);
      cyc(1'b1, 1'b0, 3, 129);
      chk("ord_n", 32'(rn0), 32'({2'd3, 2'd1, 2'd2}));
      chk("ord_t", 32'(rt0), 32'({8'd129, 8'd128, 8'd127}));
      chk("ord_cnt", 32'(cn0), 32'd3);
      cyc(1'b1, 1'b0, 2, 126);
      chk("imp_t", 32'(rt0), 32'({8'd129, 8'd128, 8'd126}));
      cyc(1'b1, 1'b0, 2, 129);
      chk("worse_t", 32'(rt0), 32'({8'd129, 8'd128, 8'd126}));
      cyc(1'b1, 1'b0, 1, 124);
      chk("move_n", 32'(rn0), 32'({2'd3, 2'd2, 2'd1}));
      chk("move_t", 32'(rt0), 32'({8'd129, 8'd126, 8'd124}));

      // ties keep arrival order; n=0 is idle
      cyc(1'b0, 1'b0, 0, 0);
      cyc(1'b1, 1'b0, 1, 50);
      cyc(1'b1, 1'b0, 2, 50);
      chk("tie_n", 32'(rn0), 32'({2'd0, 2'd2, 2'd1}));
      cyc(1'b1, 1'b0, 0, 0);
      chk("idle_t", 32'(rt0), 32'({8'd255, 8'd50, 8'd50}));

      // full ranking drop with K=2
      cyc(1'b0, 1'b0, 0, 0);
      cyc(1'b1, 1'b0, 1, 10);
      cyc(1'b1, 1'b0, 2, 20);
      cyc(1'b1, 1'b0, 3, 15);
      chk("k2_n", 32'(rn1), 32'({2'd3, 2'd1}));
      cyc(1'b1, 1'b0, 2, 30);
      chk("k2_drop_t", 32'(rt1), 32'({8'd15, 8'd10}));

      // clr with and without a sample
      cyc(1'b1, 1'b1, 3, 200);
      chk("clr_cnt", 32'(cn0), 32'd1);
      chk("clr_n", 32'(rn0), 32'({2'd0, 2'd0, 2'd3}));
      chk("clr_t", 32'(rt0), 32'({8'd255, 8'd255, 8'd200}));
      cyc(1'b1, 1'b1, 0, 0);
      chk("clr0_cnt", 32'(cn0), 32'd0);

      // max mode and reset overriding a sample
      cyc(1'b0, 1'b0, 0, 0);
      cyc(1'b1, 1'b0, 1, 5);
      cyc(1'b1, 1'b0, 2, 9);
      chk("max_nb", 32'(nb2), 32'd2);
      chk("max_tb", 32'(tb2), 32'd9);
      cyc(1'b0, 1'b0, 3, 99);
      chk("rstov_t", 32'(rt2), 32'd0);
      chk("rstov_cnt", 32'(cn2), 32'd0);
      cyc(1'b1, 1'b0, 3, 77);
      chk("post_rst_nb", 32'(nb0), 32'd3);

      // random run
      for (int k = 0; k < 200; k++) begin
         r  = ($urandom_range(0, 49) != 0);
         c  = ($urandom_range(0, 19) == 0);
         nn = $urandom_range(0, 3);
         case ($urandom_range(0, 3))
            0:       tt = $urandom_range(0, 255);
            1:       tt = ($urandom_range(0, 1) != 0) ? 255 : 0;
            default: tt = $urandom_range(100, 104);
         endcase
         cyc(r, c, nn, tt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
